ram_master: RTL and testbench
=============================

// Module: ram_master
// PURPOSE
//  Initiator for the single-port-pair RAM (sync write, registered 1-cycle read).
//  Accepts burst read/write requests from the CPU/loader via valid/ready, sequences
//  RAM write/read strobes, and streams read data back with backpressure.
//  Sits between datapath/control unit and the ram instance.
// PARAMETERS
//  addr_size  8  RAM address width; addresses wrap modulo 2**addr_size
//  data_size  8  RAM word width
//  len_size   4  burst length field width; beats = req_len+1 (1..2**len_size)
//  prot_limit 16 first writable address (used only with RAM_MASTER_PROT_EN)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   1          request offered
//  req_ready    out  1          high only in IDLE
//  req_write    in   1          1=write burst, 0=read burst
//  req_addr     in   addr_size  start address
//  req_len      in   len_size   beats-1
//  wdata        in   data_size  write beat data
//  wdata_valid  in   1          write beat offered
//  wdata_ready  out  1          high in WR state
//  rdata        out  data_size  read beat data (registered)
//  rdata_valid  out  1          read beat held until rdata_ready
//  rdata_ready  in   1          consumer accepts beat
//  rdata_last   out  1          qualifies final read beat
//  busy         out  1          state != IDLE
//  err          out  1          sticky protect violation (0 without macro)
//  ram_write_en out  1  / ram_write_adress out addr_size / ram_data_in out data_size
//  ram_rd_en    out  1  / ram_rd_adress out addr_size / ram_data_out in data_size
// BEHAVIOUR
//  Reset: state=IDLE, addr/beat counters=0, rdata=0, rdata_valid=0, rdata_last=0,
//   err=0, all ram_* outputs 0; busy=0. Reset mid-burst aborts it; no strobe after.
//  States: IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT.
//  IDLE: req_valid&req_ready -> latch addr,len; write?WR:RD_ISSUE. No RAM strobes.
//  WR: wdata_ready=1; beat on wdata_valid: ram_write_en=1 (comb), address=addr,
//   data=wdata; addr++, remaining--; last beat -> IDLE. Idle cycles allowed.
//  RD_ISSUE: ram_rd_en=1 at addr for one cycle -> RD_WAIT.
//  RD_WAIT: capture ram_data_out into rdata, rdata_valid<=1, rdata_last<=(remaining==0)
//   -> RD_OUT.
//  RD_OUT: hold rdata stable while !rdata_ready. On handshake: last -> IDLE,
//   rdata_valid<=0; else addr++, ram_rd_en=1 at addr+1 same cycle -> RD_WAIT.
//   Sustained throughput 1 beat / 2 cycles; first beat 3 cycles after accept.
//  Wrap: addr 2**addr_size-1 increments to 0, burst continues.
//  ram_write_en and ram_rd_en never high in the same cycle.
//  RAM own rst reloads contents; requests during ram rst are caller's fault.
// CONFIGURATION
//  RAM_MASTER_PROT_EN defined: WR beats with addr<prot_limit are consumed
//   (wdata_ready=1) but ram_write_en held 0; err set, sticky until rst.
//   Reads unaffected. Undefined: all writes performed, err tied 0.
// STRUCTURE
//  ram_pkg (shared include): state encodings, default addr/data widths.
//  Sub-module ram_burst_counter: addr register + remaining-beat down-counter,
//   load/step/last outputs; reused by future DMA/loader blocks.
// TESTING
//  Write addr=0x10 len=3 data 0xA0..0xA3 -> RAM[0x10..0x13]=A0..A3, busy low after.
//  Read addr=0x10 len=3, rdata_ready=1 -> A0,A1,A2,A3 every 2 cycles, last on A3.
//  Read len=1 with rdata_ready low 5 cycles -> rdata stable, no extra ram_rd_en.
//  Write addr=0xFE len=3 -> writes 0xFE,0xFF,0x00,0x01 (wrap).
//  Assert rst during read beat 2 of 4 -> outputs 0 immediately, IDLE, req_ready=1.
//  PROT_EN, prot_limit=16: write addr=0x0E len=3 -> only 0x10,0x11 written, err=1.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: definitions shared by the RAM initiator and the blocks that reuse its counter.
//   RAM_ADDR_SIZE / RAM_DATA_SIZE / RAM_LEN_SIZE : default address, word and burst-length widths
//   state_t                                      : encodings for the ram_master sequencer
package ram_pkg;
  localparam int RAM_ADDR_SIZE = 8;
  localparam int RAM_DATA_SIZE = 8;
  localparam int RAM_LEN_SIZE  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_OUT   = 3'd4
  } state_t;
endpackage

// File: rtl/ram_burst_counter.sv
// ram_burst_counter: burst address register plus remaining-beat down-counter.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : take load_addr / load_len (len = beats-1)
//   step            : advance to the next beat (addr+1 with wrap, remaining-1)
//   addr            : current beat address
//   next_addr       : addr+1, wrapping modulo 2**addr_w
//   last            : current beat is the final one (remaining == 0)
module ram_burst_counter
  import ram_pkg::*;
#(
  parameter int addr_w = RAM_ADDR_SIZE,
  parameter int len_w  = RAM_LEN_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [addr_w-1:0] load_addr,
  input  logic [len_w-1:0]  load_len,
  input  logic              step,
  output logic [addr_w-1:0] addr,
  output logic [addr_w-1:0] next_addr,
  output logic              last
);
  logic [len_w-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= next_addr;
      remaining <= remaining - 1'b1;
    end
  end

  assign next_addr = addr + 1'b1;
  assign last      = (remaining == '0);
endmodule

// File: rtl/ram_master.sv
// ram_master: burst initiator for a RAM with synchronous write and 1-cycle registered read.
//   req_*        : burst request (valid/ready), req_len = beats-1
//   wdata*       : write beat stream, accepted while in WR
//   rdata*       : registered read beat stream with backpressure, rdata_last on final beat
//   busy         : sequencer not idle
//   err          : sticky write-protect violation
//   ram_*        : strobes/addresses/data to the RAM; strobe outputs are combinational
// Optional feature macro: RAM_MASTER_PROT_EN -- writes below prot_limit are consumed
// but suppressed and set err. Without it every write is performed and err is 0.
module ram_master
  import ram_pkg::*;
#(
  parameter int addr_size  = RAM_ADDR_SIZE,
  parameter int data_size  = RAM_DATA_SIZE,
  parameter int len_size   = RAM_LEN_SIZE,
  parameter int prot_limit = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [addr_size-1:0] req_addr,
  input  logic [len_size-1:0]  req_len,
  input  logic [data_size-1:0] wdata,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  output logic [data_size-1:0] rdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic                 rdata_last,
  output logic                 busy,
  output logic                 err,
  output logic                 ram_write_en,
  output logic [addr_size-1:0] ram_write_adress,
  output logic [data_size-1:0] ram_data_in,
  output logic                 ram_rd_en,
  output logic [addr_size-1:0] ram_rd_adress,
  input  logic [data_size-1:0] ram_data_out
);
  state_t               state, state_nxt;
  logic                 ld, stp, last, prot_hit;
  logic [addr_size-1:0] addr, next_addr;

  ram_burst_counter #(.addr_w(addr_size), .len_w(len_size)) u_cnt (
    .clk(clk), .rst(rst), .load(ld), .load_addr(req_addr), .load_len(req_len),
    .step(stp), .addr(addr), .next_addr(next_addr), .last(last)
  );

`ifdef RAM_MASTER_PROT_EN
  assign prot_hit = int'(addr) < prot_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         err <= 1'b0;
    else if (state == ST_WR && wdata_valid && prot_hit) err <= 1'b1;
  end
`else
  assign prot_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    wdata_ready      = 1'b0;
    ld               = 1'b0;
    stp              = 1'b0;
    ram_write_en     = 1'b0;
    ram_write_adress = '0;
    ram_data_in      = '0;
    ram_rd_en        = 1'b0;
    ram_rd_adress    = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ld        = 1'b1;
          state_nxt = req_write ? ST_WR : ST_RD_ISSUE;
        end
      end
      ST_WR: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          // protected beats are still consumed so the source never stalls
          ram_write_en     = !prot_hit;
          ram_write_adress = addr;
          ram_data_in      = wdata;
          if (last) state_nxt = ST_IDLE;
          else      stp       = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        ram_rd_en     = 1'b1;
        ram_rd_adress = addr;
        state_nxt     = ST_RD_WAIT;
      end
      ST_RD_WAIT: state_nxt = ST_RD_OUT;
      ST_RD_OUT: begin
        if (rdata_ready) begin
          if (rdata_last) state_nxt = ST_IDLE;
          else begin
            // issue the next read in the handshake cycle: 2 cycles per beat
            stp           = 1'b1;
            ram_rd_en     = 1'b1;
            ram_rd_adress = next_addr;
            state_nxt     = ST_RD_WAIT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else if (state == ST_RD_WAIT) begin
      rdata       <= ram_data_out;
      rdata_valid <= 1'b1;
      rdata_last  <= last;
    end else if (state == ST_RD_OUT && rdata_ready) begin
      // drop valid on every handshake so a beat is never seen twice
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: table-driven bench for ram_master with a RAM model and a read scoreboard.
module tb_ram_master;
  localparam int AW = 8, DW = 8, LW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 0, req_write = 0, wdata_valid = 0, rdata_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          req_ready, wdata_ready, rdata_valid, rdata_last, busy, err;
  logic [DW-1:0] rdata, ram_data_in, ram_data_out;
  logic          ram_write_en, ram_rd_en;
  logic [AW-1:0] ram_write_adress, ram_rd_adress;

  ram_master #(.addr_size(AW), .data_size(DW), .len_size(LW), .prot_limit(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata_last(rdata_last), .busy(busy), .err(err),
    .ram_write_en(ram_write_en), .ram_write_adress(ram_write_adress),
    .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en), .ram_rd_adress(ram_rd_adress),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] exp_mem [0:255];
  initial ram_data_out = '0;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_adress] <= ram_data_in;
    if (ram_rd_en)    ram_data_out <= mem[ram_rd_adress];
  end

  int pass_n = 0, tot_n = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard: gap = expected cycles since accept/previous beat (0 = unchecked)
  typedef struct { logic [DW-1:0] d; bit last; int gap; } exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  int cyc = 0, ref_cyc = 0, pop_n = 0, rd_cnt = 0, overlap = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_rd_en) rd_cnt++;
    if (ram_rd_en && ram_write_en) overlap++;
    if (!rst && rdata_valid && rdata_ready) begin
      if (exp_q.size() == 0) check("rd_unexpected_beat", 1, 0);
      else begin
        e_m = exp_q.pop_front();
        check("rd_data", rdata, e_m.d);
        check("rd_last", rdata_last, e_m.last);
        if (e_m.gap > 0) check("rd_gap", cyc - ref_cyc, e_m.gap);
      end
      ref_cyc = cyc;
      pop_n++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit prot_blk(input logic [AW-1:0] a);
`ifdef RAM_MASTER_PROT_EN
    return a < 8'd16;
`else
    return a > 8'hFF;
`endif
  endfunction

  task automatic send_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = a; req_len = l;
    tick();
    req_valid = 0;
    ref_cyc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(name, busy, 0);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] d0, input bit idle);
    logic [AW-1:0] ad;
    send_req(1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (idle && i[0]) begin wdata_valid = 0; tick(); end
      check("wr_ready", wdata_ready, 1);
      ad = AW'(int'(a) + i);
      wdata = DW'(int'(d0) + i); wdata_valid = 1;
      if (!prot_blk(ad)) exp_mem[ad] = wdata;
      tick();
    end
    wdata_valid = 0;
    check("wr_busy_after", busy, 0);
    for (int i = 0; i <= int'(l); i++) begin
      ad = AW'(int'(a) + i);
      check("wr_mem", mem[ad], exp_mem[ad]);
    end
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int rd0;
    exp_t e;
    rd0 = rd_cnt;
    for (int i = 0; i <= int'(l); i++) begin
      e.d = exp_mem[AW'(int'(a) + i)]; e.last = (i == int'(l)); e.gap = 2;
      exp_q.push_back(e);
    end
    send_req(0, a, l);
    wait_idle("rd_done");
    check("rd_q_empty", exp_q.size(), 0);
    check("rd_strobes", rd_cnt - rd0, int'(l) + 1);
  endtask

  typedef struct { bit wr; logic [AW-1:0] a; logic [LW-1:0] l; logic [DW-1:0] d0; bit idle; } vec_t;
  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rd0;
    exp_t e;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    vt[0] = '{1, 8'h10, 4'd3,  8'hA0, 0};
    vt[1] = '{0, 8'h10, 4'd3,  8'h00, 0};
    vt[2] = '{1, 8'hFE, 4'd3,  8'h50, 0};
    vt[3] = '{0, 8'hFE, 4'd3,  8'h00, 0};
    vt[4] = '{1, 8'h40, 4'd0,  8'h77, 0};
    vt[5] = '{0, 8'h40, 4'd0,  8'h00, 0};
    vt[6] = '{1, 8'h80, 4'd15, 8'h00, 1};
    vt[7] = '{0, 8'h80, 4'd15, 8'h00, 0};

    // reset state
    #3;
    check("rst_state", {busy, req_ready, rdata_valid, rdata_last, err, wdata_ready}, 6'b010000);
    check("rst_ram", {ram_write_en, ram_rd_en, ram_write_adress, ram_rd_adress, ram_data_in}, '0);
    check("rst_rdata", rdata, 0);
    tick(); rst = 0; tick();

    for (int i = 0; i < 8; i++) begin
      if (vt[i].wr) wr_burst(vt[i].a, vt[i].l, vt[i].d0, vt[i].idle);
      else          rd_burst(vt[i].a, vt[i].l);
    end

    // backpressure: first beat held 5 cycles, no further read strobes
    rd0 = rd_cnt; rdata_ready = 0;
    e.d = exp_mem[8'h10]; e.last = 0; e.gap = 0; exp_q.push_back(e);
    e.d = exp_mem[8'h11]; e.last = 1; e.gap = 2; exp_q.push_back(e);
    send_req(0, 8'h10, 4'd1);
    n = 0;
    while (!rdata_valid && n < 50) begin tick(); n++; end
    check("bp_valid", rdata_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", rdata, exp_mem[8'h10]);
      check("bp_hold_valid", {rdata_valid, rdata_last}, 2'b10);
    end
    check("bp_no_extra_rd", rd_cnt - rd0, 1);
    @(posedge clk); #1; rdata_ready = 1;
    wait_idle("bp_done");
    check("bp_strobes", rd_cnt - rd0, 2);
    check("bp_q_empty", exp_q.size(), 0);

    // reset during beat 2 of 4
    pop_n = 0;
    for (int i = 0; i < 4; i++) begin
      e.d = exp_mem[8'h10 + i]; e.last = (i == 3); e.gap = 2; exp_q.push_back(e);
    end
    send_req(0, 8'h10, 4'd3);
    n = 0;
    while (pop_n < 1 && n < 50) begin tick(); n++; end
    n = 0;
    while (!rdata_valid && n < 50) begin tick(); n++; end
    check("mid_beat2_valid", rdata_valid, 1);
    rst = 1; #1;
    check("mid_rst_out", {rdata_valid, rdata_last, busy, req_ready, ram_rd_en}, 5'b00010);
    check("mid_rst_rdata", rdata, 0);
    exp_q.delete();
    rd0 = rd_cnt;
    tick(); tick(); rst = 0;
    repeat (4) tick();
    check("mid_no_strobe", rd_cnt - rd0, 0);
    check("mid_idle", {busy, req_ready}, 2'b01);
    rd_burst(8'h10, 4'd3);

`ifdef RAM_MASTER_PROT_EN
    wr_burst(8'h0E, 4'd3, 8'hC0, 0);
    check("prot_err", err, 1);
`else
    check("err_zero", err, 0);
`endif
    check("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
